// File: rtl/loadable_down_counter_pkg.sv
// Shared constants and state type for the loadable down counter.
package loadable_down_counter_pkg;

    localparam int DEFAULT_N = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RUN    = ST_RUN,
        FINISH = ST_DONE
    } state_t;

endpackage

// File: rtl/loadable_down_counter_if.sv
// Control/status bundle of the loadable down counter; master drives commands, slave is the counter.
interface loadable_down_counter_if #(
    parameter int N = loadable_down_counter_pkg::DEFAULT_N
);
    logic         enable;
    logic         load;
    logic [N-1:0] load_value;
    logic [N-1:0] Q;
    logic         terminal_count;
    logic         done;
    logic         busy;

    modport master (
        output enable, load, load_value,
        input  Q, terminal_count, done, busy
    );

    modport slave (
        input  enable, load, load_value,
        output Q, terminal_count, done, busy
    );
endinterface

// File: rtl/loadable_down_counter_core.sv
// N-bit borrow-chain toggle register: load has priority over decrement; no state knowledge.
module down_count_core
    import loadable_down_counter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         dec_en,
    output logic [N-1:0] q
);

    logic [N-1:0] t;

    // Bit i toggles when decrementing and every lower bit is 0 (a borrow ripples up).
    always_comb begin
        t[0] = dec_en;
        for (int i = 1; i < N; i++) begin
            t[i] = t[i-1] & ~q[i-1];
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/loadable_down_counter.sv
// Loadable down counter: IDLE/RUN/DONE control, flags and optional periodic reload.
// Define LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN to restart from the reload register when enabled in DONE.
module loadable_down_counter
    import loadable_down_counter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      reset,
    loadable_down_counter_if.slave    bus
);

    state_t       state, state_n;
    logic         core_load;
    logic [N-1:0] core_data;
    logic         dec_en;
    logic         done_n;

`ifdef LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [N-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
        end else if (bus.load && bus.load_value != '0) begin
            reload_q <= bus.load_value;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        core_load = 1'b0;
        core_data = bus.load_value;
        dec_en    = 1'b0;
        done_n    = 1'b0;

        if (bus.load) begin
            // Load beats enable and swallows any done that would have fired this cycle.
            core_load = 1'b1;
            state_n   = (bus.load_value != '0) ? RUN : FINISH;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.enable) begin
                        dec_en = 1'b1;
                        if (bus.Q == N'(1)) begin
                            state_n = FINISH;
                            done_n  = 1'b1;
                        end
                    end
                end
                FINISH: begin
`ifdef LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN
                    if (bus.enable && reload_q != '0) begin
                        core_load = 1'b1;
                        core_data = reload_q;
                        state_n   = RUN;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Flags are registered from the next state, so they line up with the new Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            bus.terminal_count <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
        end else begin
            state              <= state_n;
            bus.terminal_count <= (state_n == FINISH);
            bus.busy           <= (state_n == RUN);
            bus.done           <= done_n;
        end
    end

    down_count_core #(.N(N)) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (core_load),
        .load_value (core_data),
        .dec_en     (dec_en),
        .q          (bus.Q)
    );

endmodule

// File: doc/loadable_down_counter.md
Name: loadable_down_counter

Overview:
- N-bit synchronous down counter with parallel load, count enable, terminal-count flag and a one-cycle done pulse.
- It is the counting-down counterpart to the team's ripple-enable up counter.
- Used as a programmable interval timer and delay generator: software or an FSM loads a count, enables it, and waits for done.
- Built from a toggle/borrow chain: bit i toggles when enabled and all lower bits are 0.

Parameters:
- N, 4, counter width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; decrements Q by 1 per cycle while in RUN.
- load  input  1  parallel-load strobe.
- load_value  input  N  value captured on load.
- Q  output  N  current count (registered).
- terminal_count  output  1  registered; high whenever Q == 0 and state is DONE.
- done  output  1  registered one-cycle pulse on the 1 -> 0 transition of Q.
- busy  output  1  registered; high in state RUN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled at the clk edge):
  - Q = 0, terminal_count = 0, done = 0, busy = 0.
  - Reload register = 0, state = IDLE.
- Priority per cycle: reset > load > enable.
- States: IDLE, RUN, DONE.
- IDLE:
  - Q holds; enable is ignored.
  - load with load_value != 0 -> Q = load_value, reload register = load_value, next state RUN.
  - load with load_value == 0 -> Q = 0, next state DONE, no done pulse.
- RUN:
  - enable = 0 -> Q holds (pause).
  - enable = 1 and Q > 1 -> Q = Q - 1.
  - enable = 1 and Q == 1 -> Q = 0, done = 1 for exactly one cycle, next state DONE.
- DONE:
  - Q stays 0 and terminal_count = 1.
  - enable is ignored; the counter never wraps to 2^N - 1.
  - Only load leaves DONE.
- Load in any state:
  - Overrides enable in the same cycle; no decrement is applied to the loaded value.
  - Load during RUN restarts the count immediately.
  - A pending done in that cycle is suppressed.
- Decrement implementation:
  - Borrow chain: t[0] = enable & run.
  - t[i] = t[i-1] & ~Q[i-1].
  - Q[i] toggles when t[i] = 1.
  - Q == 0 is never decremented (guarded by state).
- Latency:
  - Load is visible on Q the cycle after the strobe.
  - A count of K with continuous enable asserts done K cycles after Q first shows K.
- Reset during RUN: the count is aborted and all outputs return to reset values on the next edge.

Optional Feature:
- Macro: LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - In DONE, enable = 1 -> Q = reload register and state RUN on the next edge, giving a periodic done with period (reload + 1) enabled cycles.
  - terminal_count is high only during the DONE cycle.
  - A reload register of 0 stays in DONE.
- Undefined: DONE is sticky as described above, and the reload register is not synthesized.

Decomposition:
- Shared package/header holds:
  - State encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - The default width constant.
- One natural sub-module: down_count_core.
  - N-bit borrow-chain toggle register with load and decrement-enable.
  - No state knowledge.
  - The FSM, flags and reload logic live in loadable_down_counter.

Test Plan:
- Reset, then load load_value = 5 and hold enable = 1 -> Q reads 5, 4, 3, 2, 1, 0; done is high the single cycle Q becomes 0; terminal_count = 1; busy drops with done.
- Load 12 with enable toggling 1, 0, 1, 0 -> Q decrements only on enabled cycles (12, 11, 11, 10, 10); no done.
- During RUN at Q = 3, assert load = 1 with load_value = 9 and enable = 1 in the same cycle -> Q = 9 next cycle (no decrement); no done pulse.
- In DONE, hold enable = 1 for 4 cycles -> without the macro Q stays 0 with no new done; with LOADABLE_DOWN_COUNTER_AUTO_RELOAD_EN and reload = 3, Q reads 3, 2, 1, 0 with done every 4th enabled cycle.
- Load 0 -> state DONE, Q = 0, terminal_count = 1, done never asserts.
- N = 4: load 15, run to 0, and assert reset when Q = 7 -> Q = 0, busy = 0, done = 0 next edge; a following load of 1 with enable gives done after 1 cycle.
